// File: rtl/line_fill_pkg.sv
// Types and sizing helpers shared by the line-fill engine and the data cache.
package line_fill_pkg;
    localparam int DEF_WORD_W      = 64;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_BLOCK_WORDS = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} line_fill_state_t;

    function automatic int lf_off_w(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int lf_cnt_w(input int block_words);
        return $clog2(block_words) + 1;
    endfunction

    localparam int DEF_OFF_W = lf_off_w(DEF_BLOCK_WORDS);
    localparam int DEF_CNT_W = lf_cnt_w(DEF_BLOCK_WORDS);
endpackage

// File: rtl/line_fill_watchdog.sv
// Stall watchdog for the line-fill engine: counts idle cycles of an active fill
// and flags expiry on the TIMEOUT_CYCLES-th consecutive one.
module line_fill_watchdog
    import line_fill_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
)(
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = active && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!active || clear || expire) cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/line_fill_unit.sv
// Critical-word-first block fill engine between the data cache and memory.
// Optional watchdog abort is enabled by defining LINE_FILL_TIMEOUT_EN.
module line_fill_unit
    import line_fill_pkg::*;
#(
    parameter int WORD_W          = DEF_WORD_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int BLOCK_WORDS     = DEF_BLOCK_WORDS,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 255
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          fill_req,
    input  logic [ADDR_W-1:0]             fill_addr,
    output logic                          fill_busy,
    output logic                          fill_crit_valid,
    output logic [WORD_W-1:0]             fill_crit_data,
    output logic                          fill_done,
    output logic                          fill_err,
    output logic [BLOCK_WORDS*WORD_W-1:0] fill_line,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_req_addr,
    input  logic                          mem_rsp_valid,
    input  logic [WORD_W-1:0]             mem_rsp_data
);
    localparam int OFF_W = lf_off_w(BLOCK_WORDS);
    localparam int CNT_W = lf_cnt_w(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTSTANDING);

    if (BLOCK_WORDS < 2 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 ||
        MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > BLOCK_WORDS || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("line_fill_unit: unsupported parameter set");
    end

    line_fill_state_t state_q, state_d;
    logic [ADDR_W-OFF_W-1:0]            base_q, base_d;
    logic [OFF_W-1:0]                   crit_q, crit_d;
    logic [CNT_W-1:0]                   issued_q, issued_d, received_q, received_d;
    logic [CNT_W-1:0]                   inflight_d;
    logic                               req_valid_q, req_valid_d;
    logic                               crit_valid_q, crit_valid_d;
    logic [WORD_W-1:0]                  crit_data_q, crit_data_d;
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] line_q, line_d;
    logic                               active, req_hs, rsp_acc, wd_expire;
    logic [OFF_W-1:0]                   req_off, rsp_slot;

    assign active   = (state_q == ISSUE) || (state_q == DRAIN);
    assign req_hs   = req_valid_q && mem_req_ready;
    assign rsp_acc  = active && mem_rsp_valid;
    // Offset sums are OFF_W wide, so the wrap is free and base bits never move.
    assign req_off  = crit_q + issued_q[OFF_W-1:0];
    assign rsp_slot = crit_q + received_q[OFF_W-1:0];

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        crit_d       = crit_q;
        issued_d     = issued_q + CNT_W'(req_hs);
        received_d   = received_q + CNT_W'(rsp_acc);
        inflight_d   = issued_d - received_d;
        req_valid_d  = 1'b0;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;
        line_d       = line_q;
        if (rsp_acc) begin
            line_d[rsp_slot] = mem_rsp_data;
            if (received_q == '0) begin
                crit_data_d  = mem_rsp_data;
                crit_valid_d = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    base_d      = fill_addr[ADDR_W-1:OFF_W];
                    crit_d      = fill_addr[OFF_W-1:0];
                    issued_d    = '0;
                    received_d  = '0;
                    req_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                req_valid_d = (issued_d != FULL) && (inflight_d < LIMIT);
                if (issued_d == FULL) state_d = DRAIN;
                if (wd_expire) begin
                    req_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            DRAIN: begin
                if (received_d == FULL) state_d = DONE;
                if (wd_expire)          state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            crit_q       <= '0;
            issued_q     <= '0;
            received_q   <= '0;
            req_valid_q  <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            line_q       <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            crit_q       <= crit_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            req_valid_q  <= req_valid_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
            line_q       <= line_d;
        end
    end

`ifdef LINE_FILL_TIMEOUT_EN
    logic fill_err_q;

    line_fill_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .active (active),
        .clear  (req_hs || rsp_acc),
        .expire (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) fill_err_q <= 1'b0;
        else       fill_err_q <= wd_expire;
    end
    assign fill_err = fill_err_q;
`else
    assign wd_expire = 1'b0;
    assign fill_err  = 1'b0;
`endif

    assign fill_busy       = active;
    assign fill_crit_valid = crit_valid_q;
    assign fill_crit_data  = crit_data_q;
    assign fill_done       = (state_q == DONE);
    assign fill_line       = line_q;
    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = {base_q, req_off};
endmodule

// File: tb/tb_line_fill_unit.sv
// Scoreboard bench for line_fill_unit: two instances (MAX_OUTSTANDING 4 and 1)
// share one memory model selected by sel.
module tb_line_fill_unit;
    localparam int WW = 64, AW = 32, BW = 4, TO = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset = 1'b1, fill_req = 1'b0, sel = 1'b0;
    logic [AW-1:0] fill_addr = '0;
    logic          mem_ready = 1'b0, mem_rv = 1'b0;
    logic [WW-1:0] mem_rd = '0;

    logic             busy_a, cv_a, done_a, err_a, rqv_a, busy_b, cv_b, done_b, err_b, rqv_b;
    logic [WW-1:0]    cd_a, cd_b;
    logic [BW*WW-1:0] line_a, line_b;
    logic [AW-1:0]    rqa_a, rqa_b;

    line_fill_unit #(.WORD_W(WW), .ADDR_W(AW), .BLOCK_WORDS(BW), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(TO)) u_dut_a (
        .clock(clock), .reset(reset), .fill_req(fill_req & ~sel), .fill_addr(fill_addr),
        .fill_busy(busy_a), .fill_crit_valid(cv_a), .fill_crit_data(cd_a), .fill_done(done_a),
        .fill_err(err_a), .fill_line(line_a), .mem_req_valid(rqv_a), .mem_req_ready(mem_ready & ~sel),
        .mem_req_addr(rqa_a), .mem_rsp_valid(mem_rv & ~sel), .mem_rsp_data(mem_rd));

    line_fill_unit #(.WORD_W(WW), .ADDR_W(AW), .BLOCK_WORDS(BW), .MAX_OUTSTANDING(1), .TIMEOUT_CYCLES(TO)) u_dut_b (
        .clock(clock), .reset(reset), .fill_req(fill_req & sel), .fill_addr(fill_addr),
        .fill_busy(busy_b), .fill_crit_valid(cv_b), .fill_crit_data(cd_b), .fill_done(done_b),
        .fill_err(err_b), .fill_line(line_b), .mem_req_valid(rqv_b), .mem_req_ready(mem_ready & sel),
        .mem_req_addr(rqa_b), .mem_rsp_valid(mem_rv & sel), .mem_rsp_data(mem_rd));

    logic             cur_busy, cur_cv, cur_done, cur_err, cur_rqv;
    logic [WW-1:0]    cur_cd;
    logic [BW*WW-1:0] cur_line;
    logic [AW-1:0]    cur_rqa;
    assign cur_busy = sel ? busy_b : busy_a;
    assign cur_cv   = sel ? cv_b   : cv_a;
    assign cur_done = sel ? done_b : done_a;
    assign cur_err  = sel ? err_b  : err_a;
    assign cur_rqv  = sel ? rqv_b  : rqv_a;
    assign cur_cd   = sel ? cd_b   : cd_a;
    assign cur_line = sel ? line_b : line_a;
    assign cur_rqa  = sel ? rqa_b  : rqa_a;

    int checks = 0, errors = 0;
    int cyc = 0, hs_cnt = 0, rsp_cnt = 0, max_out = 4, rdy_mode = 0;
    int crit_cyc = -1, done_cyc = -1, err_cyc = -1;
    bit err_exp = 0, spur = 0, rv_real = 0, prev_stall = 0;
    logic [AW-1:0]    prev_addr = '0;
    logic [WW-1:0]    key = '0, spur_data = '0;
    logic [AW-1:0]    exp_addr[$], pend[$];
    logic [WW-1:0]    exp_crit[$];
    logic [BW*WW-1:0] exp_line[$];

    // One cycle: observe at negedge (scoreboard pops), then drive memory for the next cycle.
    task automatic tick();
        logic [AW-1:0] a;
        logic [WW-1:0] d;
        logic [BW*WW-1:0] l;
        @(negedge clock);
        if (prev_stall && !cur_err) begin
            checks++;
            if (cur_rqv !== 1'b1 || cur_rqa !== prev_addr)
                begin errors++; $display("FAIL stall_hold cyc=%0d valid=%b addr=%h required valid=1 addr=%h", cyc, cur_rqv, cur_rqa, prev_addr); end
        end
        if (cur_rqv) begin
            checks++;
            if (hs_cnt - rsp_cnt >= max_out)
                begin errors++; $display("FAIL outstanding cyc=%0d inflight=%0d required below %0d", cyc, hs_cnt - rsp_cnt, max_out); end
        end
        if (cur_rqv && mem_ready) begin
            checks++;
            if (exp_addr.size() == 0) begin errors++; $display("FAIL req_addr cyc=%0d got unexpected request %h", cyc, cur_rqa); end
            else begin
                a = exp_addr.pop_front();
                if (cur_rqa !== a) begin errors++; $display("FAIL req_addr cyc=%0d got %h required %h", cyc, cur_rqa, a); end
            end
            pend.push_back(cur_rqa);
            hs_cnt++;
        end
        if (mem_rv && rv_real) rsp_cnt++;
        if (cur_cv) begin
            crit_cyc = cyc;
            checks++;
            if (exp_crit.size() == 0) begin errors++; $display("FAIL crit_data cyc=%0d unexpected pulse data=%h", cyc, cur_cd); end
            else begin
                d = exp_crit.pop_front();
                if (cur_cd !== d || cur_done !== 1'b0) begin errors++; $display("FAIL crit_data cyc=%0d got %h done=%b required %h done=0", cyc, cur_cd, cur_done, d); end
            end
        end
        if (cur_done) begin
            done_cyc = cyc;
            checks++;
            if (exp_line.size() == 0) begin errors++; $display("FAIL fill_line cyc=%0d unexpected done", cyc); end
            else begin
                l = exp_line.pop_front();
                if (cur_line !== l) begin errors++; $display("FAIL fill_line cyc=%0d got %h required %h", cyc, cur_line, l); end
            end
        end
        if (cur_err) begin
            err_cyc = cyc;
            checks++;
            if (!err_exp) begin errors++; $display("FAIL fill_err cyc=%0d unexpected error pulse", cyc); end
        end
        prev_stall = cur_rqv && !mem_ready && !reset;
        prev_addr  = cur_rqa;
        @(posedge clock);
        #1;
        cyc++;
        mem_rv  = 1'b0;
        rv_real = 1'b0;
        if (spur) begin
            mem_rv = 1'b1; mem_rd = spur_data; spur = 0;
        end else if (pend.size() != 0) begin
            a = pend.pop_front();
            mem_rv = 1'b1; mem_rd = WW'(a) ^ key; rv_real = 1'b1;
        end
        case (rdy_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: mem_ready = 1'b0;
        endcase
    endtask

    task automatic start_fill(input logic [AW-1:0] addr, input logic [WW-1:0] key_i, input bit with_line);
        logic [AW-1:0] base;
        logic [1:0] off;
        logic [BW*WW-1:0] l;
        base = {addr[AW-1:2], 2'b00};
        for (int i = 0; i < BW; i++) begin
            off = addr[1:0] + 2'(i);
            exp_addr.push_back(base | AW'(off));
            l[i*WW +: WW] = WW'(base | AW'(i)) ^ key_i;
        end
        exp_crit.push_back(WW'(addr) ^ key_i);
        if (with_line) exp_line.push_back(l);
        key = key_i; hs_cnt = 0; rsp_cnt = 0; crit_cyc = -1; done_cyc = -1; cyc = 0;
        fill_req = 1'b1; fill_addr = addr;
        tick();
        fill_req = 1'b0;
    endtask

    task automatic run_fill(input logic [AW-1:0] addr, input logic [WW-1:0] key_i, input int budget, input int glitch_cyc);
        start_fill(addr, key_i, 1'b1);
        while (done_cyc < 0 && cyc < budget) begin
            fill_req = (cyc == glitch_cyc);
            if (cyc == glitch_cyc) fill_addr = 32'h340;
            tick();
        end
        fill_req = 1'b0;
        checks++;
        if (done_cyc < 0) begin errors++; $display("FAIL fill_timeout addr=%h no fill_done within %0d cycles", addr, budget); end
        checks++;
        if (exp_addr.size() + exp_crit.size() + exp_line.size() != 0)
            begin errors++; $display("FAIL leftover addr=%h pending addr=%0d crit=%0d line=%0d required 0", addr, exp_addr.size(), exp_crit.size(), exp_line.size()); end
        exp_addr.delete(); exp_crit.delete(); exp_line.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            checks++;
            if ({cur_busy, cur_cv, cur_done, cur_err, cur_rqv} !== 5'b0)
                begin errors++; $display("FAIL reset_ctrl inst=%0d busy/cv/done/err/rqv=%b required 00000", s, {cur_busy, cur_cv, cur_done, cur_err, cur_rqv}); end
            checks++;
            if (cur_line !== '0 || cur_cd !== '0 || cur_rqa !== '0)
                begin errors++; $display("FAIL reset_data inst=%0d line=%h crit=%h addr=%h required 0", s, cur_line, cur_cd, cur_rqa); end
        end
        sel = 1'b0;
    endtask

    task automatic test_aligned();
        sel = 1'b0; max_out = 4; rdy_mode = 0;
        run_fill(32'h100, 64'h1A0, 40, -1);
        checks++;
        if (crit_cyc != 3 || done_cyc != 6)
            begin errors++; $display("FAIL aligned_latency crit_cyc=%0d done_cyc=%0d required 3 and 6", crit_cyc, done_cyc); end
        checks++;
        if (cur_cd !== 64'hA0) begin errors++; $display("FAIL crit_hold got %h required a0", cur_cd); end
    endtask

    task automatic test_wrap();
        run_fill(32'h102, 64'h0, 40, -1);
        checks++;
        if (cur_line !== {64'h103, 64'h102, 64'h101, 64'h100} || cur_cd !== 64'h102)
            begin errors++; $display("FAIL wrap_hold line=%h crit=%h", cur_line, cur_cd); end
    endtask

    task automatic test_backpressure();
        sel = 1'b1; max_out = 1; rdy_mode = 1;
        run_fill(32'h100, 64'h1A0, 100, -1);
        checks++;
        if (cur_line !== {64'hA3, 64'hA2, 64'hA1, 64'hA0} || cur_cd !== 64'hA0)
            begin errors++; $display("FAIL bp_result line=%h crit=%h", cur_line, cur_cd); end
        rdy_mode = 0; max_out = 4; sel = 1'b0;
        #0;
    endtask

    task automatic test_reset_mid();
        start_fill(32'h300, 64'h77, 1'b0);
        while (rsp_cnt < 2 && cyc < 20) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({cur_busy, cur_rqv, cur_cv} !== 3'b0 || cur_cd !== '0 || cur_line !== '0)
            begin errors++; $display("FAIL midreset_out busy/rqv/cv=%b crit=%h line=%h required 0", {cur_busy, cur_rqv, cur_cv}, cur_cd, cur_line); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cur_busy, cur_rqv, cur_cv, cur_done} !== 4'b0 || cur_line !== '0)
                begin errors++; $display("FAIL late_rsp cyc=%0d busy/rqv/cv/done=%b line=%h required 0", cyc, {cur_busy, cur_rqv, cur_cv, cur_done}, cur_line); end
        end
        exp_addr.delete(); exp_crit.delete(); exp_line.delete();
        run_fill(32'h200, 64'h5A0, 40, -1);
    endtask

    task automatic test_spurious();
        logic [BW*WW-1:0] l_before;
        logic [WW-1:0] c_before;
        l_before = {64'h7A3, 64'h7A2, 64'h7A1, 64'h7A0};
        c_before = 64'h7A0;
        spur = 1; spur_data = 64'hDEAD;
        tick(); tick();
        checks++;
        if ({cur_busy, cur_rqv, cur_cv, cur_done} !== 4'b0 || cur_line !== l_before || cur_cd !== c_before)
            begin errors++; $display("FAIL spurious busy/rqv/cv/done=%b line=%h crit=%h", {cur_busy, cur_rqv, cur_cv, cur_done}, cur_line, cur_cd); end
        run_fill(32'h101, 64'h1A0, 40, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cur_rqv !== 1'b0 || cur_busy !== 1'b0)
                begin errors++; $display("FAIL no_queue cyc=%0d rqv=%b busy=%b required 0", cyc, cur_rqv, cur_busy); end
        end
    endtask

    task automatic test_timeout();
`ifdef LINE_FILL_TIMEOUT_EN
        rdy_mode = 2; err_exp = 1; err_cyc = -1;
        start_fill(32'h180, 64'h0, 1'b0);
        while (err_cyc < 0 && cyc < 30) tick();
        checks++;
        if (err_cyc != 9 || done_cyc != -1)
            begin errors++; $display("FAIL timeout_err err_cyc=%0d done_cyc=%0d required 9 and -1", err_cyc, done_cyc); end
        checks++;
        if (cur_busy !== 1'b0 || cur_rqv !== 1'b0)
            begin errors++; $display("FAIL timeout_idle busy=%b rqv=%b required 0", cur_busy, cur_rqv); end
        exp_addr.delete(); exp_crit.delete();
        rdy_mode = 0; err_exp = 0;
        tick();
`else
        checks++;
        if (err_cyc != -1) begin errors++; $display("FAIL err_tied fill_err seen at cyc=%0d required never", err_cyc); end
`endif
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_spurious();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not complete");
        $fatal(1, "tb_line_fill_unit stuck");
    end
endmodule

// File: doc/line_fill_unit.md
# line_fill_unit

Line-fill engine between the 8-way data cache and main memory. On a cache miss it takes one word-aligned request and fetches the full 4-word block in critical-word-first wrap order over a pipelined valid/ready memory port. It returns the requested word early and the assembled block once complete, so the cache writes the line in one cycle instead of stepping through per-word states.

## Interface
- WORD_W, 64: data word width in bits.
- ADDR_W, 32: word address width.
- BLOCK_WORDS, 4: words per block; power of two, at least 2.
- MAX_OUTSTANDING, 4: memory reads in flight; 1 to BLOCK_WORDS.
- TIMEOUT_CYCLES, 255: watchdog limit; used only with the macro.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- fill_req  in  1  start a fill; sampled only in IDLE.
- fill_addr  in  ADDR_W  requested word address; low log2(BLOCK_WORDS) bits give the critical word.
- fill_busy  out  1  high from the cycle after acceptance until fill_done or fill_err.
- fill_crit_valid  out  1  one-cycle pulse: requested word available.
- fill_crit_data  out  WORD_W  requested word; held until the next accepted fill.
- fill_done  out  1  one-cycle pulse: fill_line complete.
- fill_err  out  1  one-cycle pulse: fill aborted by timeout.
- fill_line  out  BLOCK_WORDS*WORD_W  block in natural order; word i occupies bits [i*WORD_W +: WORD_W].
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  word address of the read.
- mem_rsp_valid  in  1  read data valid; responses return in request order.
- mem_rsp_data  in  WORD_W  read data.

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- Reset: state IDLE, all counters 0, and every output 0, including fill_line and fill_crit_data.
- IDLE:
  - When fill_req=1, latch base = fill_addr with the offset bits cleared, and crit = the offset bits.
  - Clear the counters and go to ISSUE.
  - fill_req is ignored in every other state; no queueing.
- ISSUE:
  - Assert mem_req_valid with mem_req_addr = base + ((crit + issued) mod BLOCK_WORDS).
  - issued increments on each mem_req_valid && mem_req_ready.
  - Deassert mem_req_valid while (issued - received) == MAX_OUTSTANDING.
  - Once issued == BLOCK_WORDS, go to DRAIN.
- Responses are accepted in ISSUE and DRAIN.
  - Write mem_rsp_data to line slot (crit + received) mod BLOCK_WORDS, then increment received.
  - The first response (received == 0) also loads fill_crit_data and pulses fill_crit_valid in the next cycle.
- DRAIN: when received reaches BLOCK_WORDS, go to DONE.
- DONE: fill_done=1 for one cycle, then IDLE. fill_line stays stable until the next fill writes to it.
- Spurious mem_rsp_valid in IDLE or DONE is dropped with no state change.
- Wrap arithmetic is modulo BLOCK_WORDS on the offset bits only; base upper bits never change.
- Counters are log2(BLOCK_WORDS)+1 bits wide.

## Timing
- The request is accepted at edge 0.
- mem_req_valid is first high in cycle 1.
- Best case (ready held high, each response 1 cycle after its request):
  - requests accepted in cycles 1–4;
  - responses in cycles 2–5;
  - fill_crit_valid in cycle 3;
  - fill_done in cycle 6.
  - Total latency 6 cycles.
- A request and a response in the same cycle are both processed.
- A response can be accepted on the same edge as the final request.
- mem_req_valid is registered and never drops without a handshake while in ISSUE, except at the outstanding limit. It does not depend combinationally on mem_req_ready.
- Reset mid-fill:
  - Return to IDLE next cycle with mem_req_valid=0 and fill_busy=0.
  - Late responses are then dropped as spurious.
- fill_crit_valid and fill_done never coincide unless BLOCK_WORDS would be 1, which is excluded.

## Configuration
- LINE_FILL_TIMEOUT_EN defined:
  - A watchdog counts cycles in ISSUE/DRAIN without a handshake or response.
  - When it reaches TIMEOUT_CYCLES: pulse fill_err, go to IDLE, leave fill_line partially updated, and do not pulse fill_done.
  - Any handshake or response resets the watchdog.
- Macro undefined:
  - No watchdog logic; fill_err is tied to 0.
  - The fill waits indefinitely.

## Structure
- line_fill_pkg holds:
  - the state enum typedef (line_fill_state_t);
  - offset-width and count-width helper constants derived from BLOCK_WORDS;
  - the default word/address widths shared with the cache.
- One sub-module, line_fill_watchdog: counter, clear and expire output. It is instantiated only under LINE_FILL_TIMEOUT_EN.

## Test plan
- Aligned fill: fill_addr=0x100, ready=1, responses 1 cycle later with data 0xA0..0xA3.
  - Expect fill_crit_data=0xA0 in cycle 3 and fill_done in cycle 6.
  - Expect fill_line words 0..3 = 0xA0..0xA3.
- Wrap fill: fill_addr=0x102, memory returns data = address.
  - Expect request addresses 0x102, 0x103, 0x100, 0x101.
  - Expect fill_crit_data=0x102 and fill_line = {0x103, 0x102, 0x101, 0x100} (word 3 down to word 0).
- Backpressure: ready toggles 1,0,0,1 and MAX_OUTSTANDING=1.
  - Never more than 1 request outstanding; mem_req_addr stable while stalled.
  - Result is the same as the aligned fill.
- Reset mid-fill: assert reset after 2 responses, then deliver 2 late responses.
  - Outputs are 0 next cycle.
  - A fresh fill to 0x200 then completes correctly.
- Spurious response in IDLE plus fill_req during busy: no state change, no extra mem_req_valid.
- With LINE_FILL_TIMEOUT_EN and TIMEOUT_CYCLES=8, hold ready=0.
  - fill_err pulses after 8 stalled cycles; fill_busy falls; there is no fill_done.
